ir_nec_decoder: RTL and testbench

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_nec_pkg.sv | 52 +++++
 rtl/ir_rx_sync.sv | 34 +++
 rtl/ir_nec_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC infrared decoder: FSM states, pulse
// window limits in microseconds and the conversion to clock cycles.
package ir_nec_pkg;

    // Width of the pulse-width counter; it saturates at all-ones.
    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP
    } nec_state_e;

    // Leader mark (nominal 9 ms low)
    localparam int unsigned LEAD_LOW_MIN_US    = 8000;
    localparam int unsigned LEAD_LOW_MAX_US    = 10000;
    // Leader space of a data frame (nominal 4.5 ms high)
    localparam int unsigned LEAD_HIGH_MIN_US   = 4000;
    localparam int unsigned LEAD_HIGH_MAX_US   = 5000;
    // Leader space of a repeat code (nominal 2.25 ms high)
    localparam int unsigned REPEAT_HIGH_MIN_US = 2000;
    localparam int unsigned REPEAT_HIGH_MAX_US = 2500;
    // Bit mark, stop mark and the space of a logical 0 (nominal 560 us)
    localparam int unsigned MARK_MIN_US        = 400;
    localparam int unsigned MARK_MAX_US        = 720;
    // Space of a logical 1 (nominal 1.69 ms)
    localparam int unsigned ONE_MIN_US         = 1400;
    localparam int unsigned ONE_MAX_US         = 1900;

    // Converts a duration in microseconds to a cycle count at clk_hz,
    // saturating at the counter's full scale.
    function automatic logic [CNT_W-1:0] us_to_cycles(input int unsigned us,
                                                      input int unsigned clk_hz);
        longint unsigned cycles;
        cycles = (64'(us) * 64'(clk_hz)) / 64'd1_000_000;
        if (cycles > 64'(20'hFFFFF)) begin
            return '1;
        end
        return cycles[CNT_W-1:0];
    endfunction

    // True when a measured width lies inside an inclusive window.
    function automatic logic in_window(input logic [CNT_W-1:0] width,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (width >= lo) && (width <= hi);
    endfunction

endpackage

// File: rtl/ir_rx_sync.sv
// Brings the asynchronous IR receiver line into the clock domain and
// flags its rising and falling transitions.
module ir_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rx_s,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic prev;

    // Two-flop synchronizer plus a delayed copy for edge detection; all
    // flops reset to the idle-high level so reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_1 <= rxd;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign rx_s = sync_2;
    assign rise = sync_2 & ~prev;
    assign fall = ~sync_2 & prev;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared protocol decoder. Measures the widths of the synchronized
// receiver pulses, walks the leader / 32 data bits / stop mark, and hands
// accepted frames straight to IR_control through hex_data.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        IRDA_RXD,
    output logic [31:0] hex_data,
    output logic        data_valid,
    output logic        repeat_pulse,
    output logic        frame_error
);

    localparam logic [CNT_W-1:0] LEAD_LOW_MIN    = us_to_cycles(LEAD_LOW_MIN_US, CLK_HZ);
    localparam logic [CNT_W-1:0] LEAD_LOW_MAX    = us_to_cycles(LEAD_LOW_MAX_US, CLK_HZ);
    localparam logic [CNT_W-1:0] LEAD_HIGH_MIN   = us_to_cycles(LEAD_HIGH_MIN_US, CLK_HZ);
    localparam logic [CNT_W-1:0] LEAD_HIGH_MAX   = us_to_cycles(LEAD_HIGH_MAX_US, CLK_HZ);
    localparam logic [CNT_W-1:0] REPEAT_HIGH_MIN = us_to_cycles(REPEAT_HIGH_MIN_US, CLK_HZ);
    localparam logic [CNT_W-1:0] REPEAT_HIGH_MAX = us_to_cycles(REPEAT_HIGH_MAX_US, CLK_HZ);
    localparam logic [CNT_W-1:0] MARK_MIN        = us_to_cycles(MARK_MIN_US, CLK_HZ);
    localparam logic [CNT_W-1:0] MARK_MAX        = us_to_cycles(MARK_MAX_US, CLK_HZ);
    localparam logic [CNT_W-1:0] ONE_MIN         = us_to_cycles(ONE_MIN_US, CLK_HZ);
    localparam logic [CNT_W-1:0] ONE_MAX         = us_to_cycles(ONE_MAX_US, CLK_HZ);

    logic             rx_s;
    logic             rise;
    logic             fall;

    nec_state_e       state;
    nec_state_e       state_next;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] win_max;
    logic             timeout;
    logic [4:0]       bit_idx;
    logic [4:0]       bit_idx_next;
    logic [31:0]      shift;
    logic [31:0]      shift_next;
    logic             is_repeat;
    logic             repeat_next;
    logic             frame_seen;
    logic             seen_next;
    logic [31:0]      hex_next;
    logic             valid_next;
    logic             rpt_next;
    logic             err_next;

    ir_rx_sync u_sync (
        .clk  (CLOCK_50),
        .rst  (reset),
        .rxd  (IRDA_RXD),
        .rx_s (rx_s),
        .rise (rise),
        .fall (fall)
    );

    // Pulse-width counter: restarts on every edge, saturates when the line idles.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pulse_cnt <= '0;
        end else if (rise || fall) begin
            pulse_cnt <= '0;
        end else if (pulse_cnt != '1) begin
            pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

    // Longest width the current state may see before the frame is abandoned.
    always_comb begin
        win_max = '1;
        case (state)
            LEAD_LOW:  win_max = LEAD_LOW_MAX;
            LEAD_HIGH: win_max = LEAD_HIGH_MAX;
            BIT_LOW:   win_max = MARK_MAX;
            BIT_HIGH:  win_max = ONE_MAX;
            STOP:      win_max = MARK_MAX;
            default:   win_max = '1;
        endcase
    end

    // A timeout wins over any edge arriving in the same cycle.
    assign timeout = (state != IDLE) && (pulse_cnt > win_max);

    // State register, frame assembly and registered one-cycle pulse outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_idx      <= '0;
            shift        <= '0;
            is_repeat    <= 1'b0;
            frame_seen   <= 1'b0;
            hex_data     <= 32'h0;
            data_valid   <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_next;
            bit_idx      <= bit_idx_next;
            shift        <= shift_next;
            is_repeat    <= repeat_next;
            frame_seen   <= seen_next;
            hex_data     <= hex_next;
            data_valid   <= valid_next;
            repeat_pulse <= rpt_next;
            frame_error  <= err_next;
        end
    end

    // Next-state decode: each state waits for the edge that ends its pulse and
    // judges the width just measured against that pulse's window.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        repeat_next  = is_repeat;
        seen_next    = frame_seen;
        hex_next     = hex_data;
        valid_next   = 1'b0;
        rpt_next     = 1'b0;
        err_next     = 1'b0;

        if (timeout) begin
            err_next   = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !rx_s) begin
                        state_next   = LEAD_LOW;
                        bit_idx_next = '0;
                        repeat_next  = 1'b0;
                    end
                end
                LEAD_LOW: begin
                    if (rise) begin
                        if (in_window(pulse_cnt, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
                            state_next = LEAD_HIGH;
                        end else begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                LEAD_HIGH: begin
                    if (fall) begin
                        if (in_window(pulse_cnt, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                            state_next   = BIT_LOW;
                            bit_idx_next = '0;
                            shift_next   = '0;
                        end else if (in_window(pulse_cnt, REPEAT_HIGH_MIN, REPEAT_HIGH_MAX)) begin
                            state_next  = STOP;
                            repeat_next = 1'b1;
                        end else begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                BIT_LOW: begin
                    if (rise) begin
                        if (in_window(pulse_cnt, MARK_MIN, MARK_MAX)) begin
                            state_next = BIT_HIGH;
                        end else begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                BIT_HIGH: begin
                    if (fall) begin
                        if (in_window(pulse_cnt, MARK_MIN, MARK_MAX) ||
                            in_window(pulse_cnt, ONE_MIN, ONE_MAX)) begin
                            shift_next[bit_idx] = in_window(pulse_cnt, ONE_MIN, ONE_MAX);
                            if (bit_idx == 5'd31) begin
                                state_next  = STOP;
                                repeat_next = 1'b0;
                            end else begin
                                state_next   = BIT_LOW;
                                bit_idx_next = bit_idx + 5'd1;
                            end
                        end else begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                STOP: begin
                    if (rise) begin
                        state_next = IDLE;
                        if (!in_window(pulse_cnt, MARK_MIN, MARK_MAX)) begin
                            err_next = 1'b1;
                        end else if (is_repeat) begin
                            rpt_next = frame_seen;
                        end else if (shift[31:24] == ~shift[23:16]) begin
                            hex_next   = shift;
                            valid_next = 1'b1;
                            seen_next  = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for the NEC decoder: directed IR waveforms, a microsecond-level
// protocol model predicting each transaction's outcome, and a per-cycle
// compare process checking pulses and hex_data against that model.
module tb_ir_nec_decoder;

    localparam int unsigned CLK_HZ   = 50_000;
    localparam int          CYCLE_US = 20;
    localparam int          GAP      = 200;

    typedef enum {EV_DATA, EV_REPEAT, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] val;
    } ev_t;

    logic        CLOCK_50;
    logic        reset;
    logic        IRDA_RXD;
    logic [31:0] hex_data;
    logic        data_valid;
    logic        repeat_pulse;
    logic        frame_error;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_fe_cyc = 0;
    int          start_cyc;
    int          delay;
    bit          model_seen = 0;
    logic [31:0] model_hex = 32'h0;
    bit          prev_pulse = 0;
    ev_t         exp_q[$];
    int          seq[$];

    ir_nec_decoder #(.CLK_HZ(CLK_HZ)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .IRDA_RXD     (IRDA_RXD),
        .hex_data     (hex_data),
        .data_valid   (data_valid),
        .repeat_pulse (repeat_pulse),
        .frame_error  (frame_error)
    );

    // Free-running clock, one cycle = 20 us at the bench's CLK_HZ
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Cycle counter used to time error pulses
    always @(posedge CLOCK_50) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Protocol model: decodes the microsecond pulse list in seq by the NEC
    // rules and queues the single outcome the decoder must report.
    task automatic model_decode();
        ev_t         e;
        logic [31:0] w;
        e.kind = EV_ERR;
        e.val  = 32'h0;
        w      = 32'h0;
        if (!in_win(seq[0], 8000, 10000)) begin
            exp_q.push_back(e);
            return;
        end
        if (in_win(seq[1], 2000, 2500)) begin
            if (!in_win(seq[2], 400, 720)) begin
                exp_q.push_back(e);
            end else if (model_seen) begin
                e.kind = EV_REPEAT;
                exp_q.push_back(e);
            end
            return;
        end
        if (!in_win(seq[1], 4000, 5000)) begin
            exp_q.push_back(e);
            return;
        end
        for (int b = 0; b < 32; b++) begin
            if (!in_win(seq[2 + 2 * b], 400, 720)) begin
                exp_q.push_back(e);
                return;
            end
            if (in_win(seq[3 + 2 * b], 1400, 1900)) begin
                w[b] = 1'b1;
            end else if (!in_win(seq[3 + 2 * b], 400, 720)) begin
                exp_q.push_back(e);
                return;
            end
        end
        if (!in_win(seq[66], 400, 720) || (w[31:24] != ~w[23:16])) begin
            exp_q.push_back(e);
            return;
        end
        e.kind     = EV_DATA;
        e.val      = w;
        model_seen = 1'b1;
        exp_q.push_back(e);
    endtask

    // Builds a full frame; even bits use the *_a widths, odd bits the *_b widths
    task automatic make_frame(input logic [31:0] word, input int lead, input int space,
                              input int mk_a, input int mk_b, input int z_a, input int z_b,
                              input int o_a, input int o_b);
        seq.delete();
        seq.push_back(lead);
        seq.push_back(space);
        for (int b = 0; b < 32; b++) begin
            seq.push_back((b % 2 == 0) ? mk_a : mk_b);
            if (word[b]) seq.push_back((b % 2 == 0) ? o_a : o_b);
            else         seq.push_back((b % 2 == 0) ? z_a : z_b);
        end
        seq.push_back(mk_a);
    endtask

    // Plays seq on the line (even entries low, odd entries high), then idles high
    task automatic apply_stimulus();
        for (int i = 0; i < seq.size(); i++) begin
            IRDA_RXD = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (seq[i] / CYCLE_US) @(negedge CLOCK_50);
        end
        IRDA_RXD = 1'b1;
    endtask

    task automatic run_case(input string name);
        model_decode();
        start_cyc = cyc;
        apply_stimulus();
        repeat (GAP) @(negedge CLOCK_50);
        check_output({name, " pending events"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        model_seen = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        IRDA_RXD = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
    endtask

    // Per-cycle compare: every pulse must match the next predicted outcome,
    // pulses are exclusive and one cycle wide, hex_data only moves on data_valid.
    always @(negedge CLOCK_50) begin
        ev_t      e;
        ev_kind_e obs;
        bit       pulse;
        pulse = data_valid | repeat_pulse | frame_error;
        if (reset) begin
            model_hex = 32'h0;
            if (pulse) check_output("pulse during reset", {29'd0, data_valid, repeat_pulse, frame_error}, 32'd0);
        end else begin
            if (pulse) begin
                check_output("pulse exclusive", 32'(data_valid + repeat_pulse + frame_error), 32'd1);
                check_output("pulse width", {31'd0, prev_pulse}, 32'd0);
                if (data_valid)        obs = EV_DATA;
                else if (repeat_pulse) obs = EV_REPEAT;
                else                   obs = EV_ERR;
                if (frame_error) last_fe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_output("unexpected pulse kind", 32'(obs), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pulse kind", 32'(obs), 32'(e.kind));
                    if (e.kind == EV_DATA) model_hex = e.val;
                end
            end
            check_output("hex_data", hex_data, model_hex);
        end
        prev_pulse = pulse;
    end

    initial begin
        reset    = 1'b1;
        IRDA_RXD = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_output("reset hex_data", hex_data, 32'h0);
        check_output("reset pulses", {29'd0, data_valid, repeat_pulse, frame_error}, 32'd0);
        do_reset();

        // Repeat code before any accepted frame: silent
        seq = '{9000, 2240, 560};
        run_case("repeat after reset");

        // Nominal frame addr 00, cmd 01
        make_frame(32'hFE01FF00, 9000, 4500, 560, 560, 560, 560, 1680, 1680);
        run_case("nominal frame");
        check_output("nominal hex literal", hex_data, 32'hFE01FF00);

        // Repeat code now that a frame has been seen
        seq = '{9000, 2240, 560};
        run_case("repeat after frame");
        check_output("repeat hex literal", hex_data, 32'hFE01FF00);

        // Command inverse wrong (02 / FC)
        make_frame(32'hFC02FF00, 9000, 4500, 560, 560, 560, 560, 1680, 1680);
        run_case("bad inverse");
        check_output("bad inverse hex literal", hex_data, 32'hFE01FF00);

        // Leader too short: error on its rising edge
        seq = '{7000};
        run_case("short leader");
        delay = last_fe_cyc - start_cyc;
        check_range("short leader error time", delay, 350, 358);

        // Line held low 12 ms: timeout shortly after 10 ms
        seq = '{12000};
        run_case("leader timeout");
        delay = last_fe_cyc - start_cyc;
        check_range("timeout error time", delay, 500, 508);
        check_output("timeout hex literal", hex_data, 32'hFE01FF00);

        // Reset in the middle of bit 16, then a complete frame
        make_frame(32'hFD02FF00, 9000, 4500, 560, 560, 560, 560, 1680, 1680);
        while (seq.size() > 34) void'(seq.pop_back());
        apply_stimulus();
        IRDA_RXD = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        do_reset();
        check_output("mid-frame reset hex", hex_data, 32'h0);
        repeat (GAP) @(negedge CLOCK_50);
        make_frame(32'hFD02FF00, 9000, 4500, 560, 560, 560, 560, 1680, 1680);
        run_case("frame after reset");
        check_output("after reset hex literal", hex_data, 32'hFD02FF00);

        // +/-10% timing, extended address (second byte not the inverse)
        make_frame(32'hA55A6A1E, 8100, 4940, 500, 620, 500, 620, 1520, 1860);
        run_case("tolerance frame A");
        check_output("tolerance A hex literal", hex_data, 32'hA55A6A1E);
        make_frame(32'h33CC0DF0, 9900, 4060, 620, 500, 620, 500, 1860, 1520);
        run_case("tolerance frame B");
        check_output("tolerance B hex literal", hex_data, 32'h33CC0DF0);

        // Repeat code at +/-10% widths
        seq = '{8200, 2040, 620};
        run_case("tolerance repeat");
        check_output("final hex literal", hex_data, 32'h33CC0DF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
